lcd_bus_monitor: RTL and testbench
==================================

LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 Parameter: SYNC_STAGES, 2, synchronizer depth on all LCD_* inputs (legal 2..3).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 LCD_E  input  1  HD44780 enable strobe, asynchronous to clk.
REQ-005 LCD_RS  input  1  register select: 0 = command, 1 = data.
REQ-006 LCD_RW  input  1  1 = read transfer; 0 = write transfer.
REQ-007 LCD_D  input  4  4-bit data bus.
REQ-008 rowA  output  128  line-1 character image; column 0 in [127:120], column 15 in [7:0].
REQ-009 rowB  output  128  line-2 character image; same packing as rowA.
REQ-010 init_done  output  1  high once the 4-bit-mode entry nibble has been decoded.
REQ-011 byte_valid  output  1  one-cycle pulse per assembled byte.
REQ-012 byte_out  output  8  last assembled byte; valid while byte_valid is high.
REQ-013 byte_rs  output  1  RS value captured with byte_out.
REQ-014 cmd_ignored  output  1  one-cycle pulse on any command byte not decoded by REQ-020..022.

Function
REQ-015 Inputs SHALL pass through SYNC_STAGES flops; a strobe is a 1->0 transition of synchronized LCD_E; RS/RW/D SHALL be sampled from the synchronized values in the cycle before the falling edge.
REQ-016 Strobes with RW=1 SHALL be discarded without changing nibble phase or any state.
REQ-017 States: INIT, HI, LO; in INIT each strobe is a single nibble; a strobe with RS=0, D=0x2 SHALL move to HI and set init_done; other INIT nibbles (e.g. 0x3) are ignored.
REQ-018 HI: captured nibble becomes byte[7:4], go to LO; LO: nibble becomes byte[3:0], byte completes, go to HI.
REQ-019 On byte completion, byte_valid, byte_out and byte_rs SHALL assert exactly one clk after the detected falling edge; row updates become visible in that same cycle.
REQ-020 Command 0x01 (clear): all 32 characters SHALL become 0x20, address := 0x00.
REQ-021 Command 0x02 or 0x03 (home): address := 0x00; characters unchanged.
REQ-022 Command with bit7=1: address := byte[6:0].
REQ-023 All other commands (function set, entry mode, display control, CGRAM address) SHALL pulse cmd_ignored and change nothing else.
REQ-024 Data byte (RS=1): if address is 0x00..0x0F, rowA column (address) := byte; if 0x40..0x4F, rowB column (address-0x40) := byte; other addresses are stored nowhere; address then increments.
REQ-025 Address increment wrap: 0x27 -> 0x40, 0x67 -> 0x00; an address set outside 0x00..0x27 / 0x40..0x67 SHALL increment normally and wrap 0x7F -> 0x00.
REQ-026 Strobes closer than SYNC_STAGES+2 clk apart are out of spec; no behaviour is guaranteed for them.
REQ-027 A strobe arriving in the same cycle as the previous byte's row update SHALL not corrupt that update (the update pipeline is one deep and independent of capture).

Reset
REQ-028 On rst: rowA and rowB all 0x20, address 0x00, state INIT, init_done 0, byte_valid 0, byte_out 0x00, byte_rs 0, cmd_ignored 0, synchronizers cleared to 0.
REQ-029 rst asserted mid-byte SHALL discard the pending high nibble; after release the next strobe is treated as an INIT nibble.

Structure
REQ-030 Shared package lcd_pkg SHALL hold: CMD_CLEAR, CMD_HOME mask, DDRAM_SET bit, CHAR_SPACE (0x20), LINE2_BASE (0x40), LINE_END (0x27/0x67), the state enum.
REQ-031 One sub-module lcd_sync_edge SHALL contain the synchronizer and falling-edge detect, outputting strobe, rs, rw, d.

Verification
REQ-032 Reset, then nibbles 3,3,3,2 (RS=0) -> init_done=1 after the 4th strobe; rows all 0x20; no byte_valid.
REQ-033 After init: cmd 0x80, data "TIME 00:05" -> rowA[127:48]="TIME 00:05", rowA[47:0] spaces, 11 byte_valid pulses.
REQ-034 Cmd 0xC0, data "0" x17 -> rowB all "0"; 17th char at address 0x50 not visible; address ends 0x51.
REQ-035 Cmd 0xA7 then data "A","B" -> "A" invisible (0x27), address wraps to 0x40, "B" lands in rowB[127:120].
REQ-036 Cmd 0x28 -> cmd_ignored pulse, rows unchanged; cmd 0x01 -> all spaces.
REQ-037 High nibble 0x4 sent, rst pulsed, then 3,3,3,2 and data 0x41 at 0x80 -> rowA[127:120]=0x41; RW=1 strobes interleaved anywhere -> identical result.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and address-sequencing helper for the HD44780
// bus monitor.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK = 8'hFE;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam int unsigned DDRAM_SET    = 7;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [6:0] LINE2_BASE    = 7'h40;
  localparam logic [6:0] LINE1_END     = 7'h27;
  localparam logic [6:0] LINE2_END     = 7'h67;

  typedef enum logic [1:0] {
    StInit,
    StHi,
    StLo
  } lcd_state_e;

  // Line ends jump to the other line; anything else counts up and wraps at 0x7F.
  function automatic logic [6:0] next_addr(input logic [6:0] a);
    if (a == LINE1_END) begin
      return LINE2_BASE;
    end else if (a == LINE2_END) begin
      return 7'h00;
    end else begin
      return a + 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Synchronises the asynchronous LCD bus and flags falling edges of E, presenting the
// bus values as they were in the cycle before the edge.
module lcd_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [3:0] d_i,
  output logic       strobe_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [3:0] d_o
);

  // Packed as {e, rs, rw, d[3:0]}
  logic [SYNC_STAGES-1:0][6:0] sync_q;
  logic [6:0]                  prev_q;
  logic [6:0]                  cur;

  assign cur = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {e_i, rs_i, rw_i, d_i}};
      prev_q <= cur;
    end
  end

  assign strobe_o = prev_q[6] & ~cur[6];
  assign rs_o     = prev_q[5];
  assign rw_o     = prev_q[4];
  assign d_o      = prev_q[3:0];

endmodule

// File: rtl/lcd_bus_monitor.sv
// Snoops an HD44780 4-bit write bus and rebuilds the two 16-character display lines
// as seen by the panel.
module lcd_bus_monitor
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [127:0] rowA,
  output logic [127:0] rowB,
  output logic         init_done,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic         cmd_ignored
);

  logic       strobe, s_rs, s_rw;
  logic [3:0] s_d;

  lcd_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .e_i     (LCD_E),
    .rs_i    (LCD_RS),
    .rw_i    (LCD_RW),
    .d_i     (LCD_D),
    .strobe_o(strobe),
    .rs_o    (s_rs),
    .rw_o    (s_rw),
    .d_o     (s_d)
  );

  lcd_state_e   state_q, state_d;
  logic [3:0]   hi_q, hi_d;
  logic [6:0]   addr_q, addr_d;
  logic [127:0] rowa_q, rowa_d, rowb_q, rowb_d;
  logic         init_done_q, init_done_d;
  logic         valid_q, valid_d;
  logic [7:0]   byte_q, byte_d;
  logic         byte_rs_q, byte_rs_d;
  logic         ign_q, ign_d;
  logic [7:0]   asm_byte;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    rowa_d      = rowa_q;
    rowb_d      = rowb_q;
    init_done_d = init_done_q;
    valid_d     = 1'b0;
    byte_d      = byte_q;
    byte_rs_d   = byte_rs_q;
    ign_d       = 1'b0;
    asm_byte    = {hi_q, s_d};

    if (strobe && !s_rw) begin
      unique case (state_q)
        StInit: begin
          if (!s_rs && s_d == 4'h2) begin
            state_d     = StHi;
            init_done_d = 1'b1;
          end
        end
        StHi: begin
          hi_d    = s_d;
          state_d = StLo;
        end
        StLo: begin
          state_d   = StHi;
          valid_d   = 1'b1;
          byte_d    = asm_byte;
          byte_rs_d = s_rs;
          if (s_rs) begin
            // Column c lives at bits [127-8c -: 8], i.e. offset (15-c)*8.
            if (addr_q[6:4] == 3'b000) begin
              rowa_d[{~addr_q[3:0], 3'b000} +: 8] = asm_byte;
            end else if (addr_q[6:4] == LINE2_BASE[6:4]) begin
              rowb_d[{~addr_q[3:0], 3'b000} +: 8] = asm_byte;
            end
            addr_d = next_addr(addr_q);
          end else if (asm_byte == CMD_CLEAR) begin
            rowa_d = {16{CHAR_SPACE}};
            rowb_d = {16{CHAR_SPACE}};
            addr_d = 7'h00;
          end else if ((asm_byte & CMD_HOME_MASK) == CMD_HOME) begin
            addr_d = 7'h00;
          end else if (asm_byte[DDRAM_SET]) begin
            addr_d = asm_byte[6:0];
          end else begin
            ign_d = 1'b1;
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      hi_q        <= 4'h0;
      addr_q      <= 7'h00;
      rowa_q      <= {16{CHAR_SPACE}};
      rowb_q      <= {16{CHAR_SPACE}};
      init_done_q <= 1'b0;
      valid_q     <= 1'b0;
      byte_q      <= 8'h00;
      byte_rs_q   <= 1'b0;
      ign_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      rowa_q      <= rowa_d;
      rowb_q      <= rowb_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      byte_rs_q   <= byte_rs_d;
      ign_q       <= ign_d;
    end
  end

  assign rowA        = rowa_q;
  assign rowB        = rowb_q;
  assign init_done   = init_done_q;
  assign byte_valid  = valid_q;
  assign byte_out    = byte_q;
  assign byte_rs     = byte_rs_q;
  assign cmd_ignored = ign_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Scoreboard bench for lcd_bus_monitor: stimulus queues expected bytes, a monitor
// process checks each byte_valid pulse; row images are checked against constants.
module tb_lcd_bus_monitor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         LCD_E = 1'b0;
  logic         LCD_RS = 1'b0;
  logic         LCD_RW = 1'b0;
  logic [3:0]   LCD_D = 4'h0;
  logic [127:0] rowA, rowB;
  logic         init_done, byte_valid, byte_rs, cmd_ignored;
  logic [7:0]   byte_out;

  lcd_bus_monitor #(
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .LCD_E      (LCD_E),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_D      (LCD_D),
    .rowA       (rowA),
    .rowB       (rowB),
    .init_done  (init_done),
    .byte_valid (byte_valid),
    .byte_out   (byte_out),
    .byte_rs    (byte_rs),
    .cmd_ignored(cmd_ignored)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pushes = 0;
  logic [9:0] exp_q[$];  // {ignored, rs, byte}

  localparam logic [127:0] SPACES = {16{8'h20}};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every byte_valid pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && byte_valid) begin
      pulses++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got %h rs=%b, queue empty", byte_out, byte_rs);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({cmd_ignored, byte_rs, byte_out} !== e) begin
          bad++;
          $display("FAIL byte: got ign=%b rs=%b %h want ign=%b rs=%b %h",
                   cmd_ignored, byte_rs, byte_out, e[9], e[8], e[7:0]);
        end
      end
    end else if (!rst && cmd_ignored) begin
      total++;
      bad++;
      $display("FAIL stray_ignore: got cmd_ignored=1 without byte_valid, want 0");
    end
  end

  task automatic strobe(input logic rs, input logic rw, input logic [3:0] d);
    @(negedge clk);
    LCD_RS = rs;
    LCD_RW = rw;
    LCD_D  = d;
    LCD_E  = 1'b1;
    repeat (4) @(negedge clk);
    LCD_E = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b, input logic with_read);
    logic ign;
    ign = !rs && b != 8'h01 && b[7:1] != 7'h01 && !b[7];
    strobe(rs, 1'b0, b[7:4]);
    if (with_read) strobe(rs, 1'b1, 4'hF);
    exp_q.push_back({ign, rs, b});
    pushes++;
    strobe(rs, 1'b0, b[3:0]);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i], 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rowA"}, rowA, SPACES);
    check({tag, "_rowB"}, rowB, SPACES);
    check({tag, "_init"}, {127'b0, init_done}, 128'd0);
    check({tag, "_valid"}, {127'b0, byte_valid}, 128'd0);
    check({tag, "_byte"}, {120'b0, byte_out}, 128'd0);
    check({tag, "_rs"}, {127'b0, byte_rs}, 128'd0);
    check({tag, "_ign"}, {127'b0, cmd_ignored}, 128'd0);
  endtask

  initial begin
    logic [127:0] exp_row;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    check("init_before_2", {127'b0, init_done}, 128'd0);
    strobe(1'b0, 1'b0, 4'h2);
    check("init_after_2", {127'b0, init_done}, 128'd1);
    check("init_rowA", rowA, SPACES);
    check("init_rowB", rowB, SPACES);
    check("init_no_bytes", 128'(pulses), 128'd0);

    send_byte(1'b0, 8'h80, 1'b0);
    send_str("TIME 00:05");
    exp_row = {"TIME 00:05", 48'h202020202020};
    check("time_rowA", rowA, exp_row);
    check("time_pulses", 128'(pulses), 128'd11);

    send_byte(1'b0, 8'hC0, 1'b0);
    for (int i = 0; i < 17; i++) send_byte(1'b1, "0", 1'b0);
    check("zeros_rowB", rowB, {16{"0"}});
    check("zeros_rowA", rowA, exp_row);

    send_byte(1'b0, 8'hA7, 1'b0);
    send_str("AB");
    check("wrap27_rowB", rowB, {"B", {15{"0"}}});
    check("wrap27_rowA", rowA, exp_row);

    send_byte(1'b0, 8'h28, 1'b0);
    check("ignored_rowA", rowA, exp_row);
    check("ignored_rowB", rowB, {"B", {15{"0"}}});
    send_byte(1'b0, 8'h01, 1'b0);
    check("clear_rowA", rowA, SPACES);
    check("clear_rowB", rowB, SPACES);

    send_byte(1'b0, 8'h85, 1'b0);
    send_str("x");
    send_byte(1'b0, 8'h02, 1'b0);
    send_str("y");
    check("home_rowA", rowA, {"y", 32'h20202020, "x", {10{8'h20}}});
    send_byte(1'b0, 8'hE7, 1'b0);
    send_str("mn");
    check("wrap67_rowA", rowA, {"n", 32'h20202020, "x", {10{8'h20}}});
    send_byte(1'b0, 8'hFF, 1'b0);
    send_str("pq");
    check("wrap7f_rowA", rowA, {"q", 32'h20202020, "x", {10{8'h20}}});
    check("wrap_rowB", rowB, SPACES);

    // Pending high nibble discarded by reset; read strobes must be invisible.
    strobe(1'b1, 1'b0, 4'h4);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    strobe(1'b0, 1'b1, 4'h2);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b0, 4'h3);
    strobe(1'b0, 1'b1, 4'h2);
    strobe(1'b0, 1'b0, 4'h3);
    check("midrst_init0", {127'b0, init_done}, 128'd0);
    strobe(1'b0, 1'b0, 4'h2);
    check("midrst_init1", {127'b0, init_done}, 128'd1);
    send_byte(1'b0, 8'h80, 1'b1);
    send_byte(1'b1, 8'h41, 1'b1);
    check("midrst_rowA", rowA, {8'h41, {15{8'h20}}});
    check("midrst_rowB", rowB, SPACES);

    repeat (5) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    check("pulse_count", 128'(pulses), 128'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
